// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the instruction fetch slice.
//   fetch_entry_t  : {pc, inst} pair buffered between imem and the decoder
//   fetch_state_t  : RUN (accepting responses) / DRAIN (discarding stale ones)
//   INST_NOP, XLEN, PC_STEP : architectural constants
package core_pkg;

   localparam int          XLEN     = 32;
   localparam int          PC_STEP  = 4;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the fetch stage's three handshakes.
//   redirect_valid/redirect_pc          : branch/jump target from execute
//   imem_req_* / imem_rsp_*             : in-order word requests to instruction memory
//   inst_valid/inst_ready/inst/inst_pc  : instruction stream toward the decoder
// modport master = the fetch stage, modport slave = its environment.
interface instr_fetch_if;
   import core_pkg::*;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;

   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst, inst_pc,
      input  inst_ready
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst, inst_pc,
      output inst_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset (storage cleared so the head reads 0)
//   push/wdata : enqueue; accepted when not full, or when full and popping
//   pop        : dequeue head (ignored when empty)
//   flush      : empty the FIFO, overrides push/pop
//   rdata      : current head entry
//   full, empty, count : occupancy
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               wdata,
   output fetch_entry_t               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic            do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the decoder.
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_fetch_if.master (redirect, imem request/response, inst stream)
//   perf_fetched, perf_stall : only with FETCH_PERF_CNT_EN defined; pops and
//                              ready-but-starved cycles, both wrapping
// Requests are credit limited so every in-flight word has a reserved FIFO slot.
// After a redirect, responses still in flight are counted down in DRAIN and dropped.
module instr_fetch
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   instr_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_stall
`endif
);

   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
   logic [OW-1:0]   outstanding, drop_cnt, drop_nxt;
   fetch_state_t    state, state_nxt;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            run_en, credit_ok, req_fire, rsp_accept, pop_eff;
   fetch_entry_t    head, push_entry;

   // Holds requests off for the first cycle out of reset so imem_req_valid
   // reads 0 while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_en <= 1'b0;
      else        run_en <= 1'b1;
   end

   // Every in-flight word plus every buffered word must fit in the FIFO.
   assign credit_ok = (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH)) &&
                      (32'(outstanding) < 32'(MAX_OUTSTANDING)) && !fifo_full;

   assign bus.imem_req_valid = run_en && !bus.redirect_valid && credit_ok;
   assign bus.imem_req_addr  = fetch_pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign target_pc          = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign pop_eff            = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

   // RUN/DRAIN follows drop_cnt; redirect reloads the drop count with every
   // response still owed after this cycle's one (if any).
   always_comb begin
      drop_nxt   = drop_cnt;
      rsp_accept = 1'b0;
      if (bus.redirect_valid) begin
         drop_nxt = outstanding - OW'(bus.imem_rsp_valid);
      end else begin
         case (state)
            RUN:     rsp_accept = bus.imem_rsp_valid;
            DRAIN:   if (bus.imem_rsp_valid) drop_nxt = drop_cnt - OW'(1);
            default: rsp_accept = 1'b0;
         endcase
      end
      state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         drop_cnt <= drop_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(bus.imem_rsp_valid);
         if (bus.redirect_valid) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
         end else begin
            if (req_fire)   fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (rsp_accept) rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
         end
      end
   end

   assign push_entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_accept),
      .pop   (bus.inst_valid && bus.inst_ready),
      .flush (bus.redirect_valid),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.inst_valid = !fifo_empty;
   assign bus.inst       = head.inst;
   assign bus.inst_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop_eff);
         perf_stall   <= perf_stall + 32'(bus.inst_ready && !bus.inst_valid);
      end
   end
`else
   // Redirect-masked pop only feeds the performance counters.
   logic unused_pop;
   assign unused_pop = pop_eff;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   import core_pkg::*;

   localparam int DEPTH = 2;
   localparam int MAXO  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if bus();
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   // Reference model: a word memory with in-order random latency, the expected
   // program-order PC stream and the number of live words waiting for the decoder.
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_req, exp_pc, first_pc, first_req, prev_pc;
   bit          got_first_pc, got_first_req, wrap_seen, found;
   int          buffered, pops, stalls, cyc;
   int          rdy_pct, dly_min, dly_max;
   int          checks = 0, errors = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      exp_req = 32'h0; exp_pc = 32'h0; prev_pc = 32'h0;
      buffered = 0; pops = 0; stalls = 0;
      got_first_pc = 0; got_first_req = 0;
   endtask

   // One clock cycle: drive at the falling edge, compare, then advance.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit ir);
      bit    rsp;
      mreq_t h;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.inst_ready     = ir;
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      rsp                = (mq.size() > 0) && (mq[0].due <= cyc);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
      #1;
      chk("inst_valid", 32'(bus.inst_valid), 32'(buffered > 0));
      if (redir) chk("req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         chk("req_addr", bus.imem_req_addr, exp_req);
         chk("req_credit", 32'(mq.size() < MAXO), 32'd1);
         if (!got_first_req) begin first_req = bus.imem_req_addr; got_first_req = 1; end
         h.addr = bus.imem_req_addr;
         h.due  = cyc + 1 + dly_min + $urandom_range(dly_max - dly_min);
         h.live = 1;
         mq.push_back(h);
         exp_req = exp_req + 32'd4;
      end
      if (bus.inst_valid && ir && !redir) begin
         chk("inst_pc", bus.inst_pc, exp_pc);
         chk("inst_word", bus.inst, memf(exp_pc));
         if (!got_first_pc) begin first_pc = bus.inst_pc; got_first_pc = 1; end
         if (bus.inst_pc == 32'h0 && prev_pc == 32'hFFFF_FFFC) wrap_seen = 1;
         prev_pc  = bus.inst_pc;
         exp_pc   = exp_pc + 32'd4;
         buffered--;
         pops++;
      end
      if (ir && !bus.inst_valid) stalls++;
      if (rsp) begin
         h = mq.pop_front();
         if (h.live && !redir) buffered++;
      end
      if (redir) begin
         buffered = 0;
         foreach (mq[i]) mq[i].live = 0;
         exp_req = {rpc[31:2], 2'b00};
         exp_pc  = {rpc[31:2], 2'b00};
         got_first_pc = 0; got_first_req = 0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int p0;
      bus.redirect_valid = 0; bus.redirect_pc = 0; bus.inst_ready = 0;
      bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
      cyc = 0; wrap_seen = 0; found = 0;
      rdy_pct = 100; dly_min = 0; dly_max = 0;
      model_clear();

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      rst_n = 1'b1;

      // 1: streaming from 0 with 1-cycle memory
      repeat (30) step(0, 0, 1);
      chk("t1_first_req", first_req, 32'h0);
      chk("t1_progress", 32'(pops >= 15), 32'd1);

      // 2: decoder stalls; buffer fills to depth and requests stop
      repeat (10) step(0, 0, 0);
      chk("t2_valid", 32'(bus.inst_valid), 32'd1);
      chk("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
      p0 = pops;
      repeat (10) step(0, 0, 1);
      chk("t2_resume", 32'(pops - p0 >= 2), 32'd1);

      // 3: redirect with two requests in flight
      dly_min = 3; dly_max = 3; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mq.size() == 2) begin step(1, 32'h100, 1); found = 1; end
         else step(0, 0, 1);
      end
      chk("t3_found", 32'(found), 32'd1);
      dly_min = 0; dly_max = 1;
      repeat (20) step(0, 0, 1);
      chk("t3_first_req", first_req, 32'h100);
      chk("t3_first_pc", first_pc, 32'h100);

      // 4: redirect coinciding with a response and a pop, unaligned target
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (bus.inst_valid && mq.size() > 0 && mq[0].due <= cyc) begin
            step(1, 32'h103, 1); found = 1;
         end else step(0, 0, 1);
      end
      chk("t4_found", 32'(found), 32'd1);
      chk("t4_flushed", 32'(bus.inst_valid), 32'd0);
      repeat (20) step(0, 0, 1);
      chk("t4_first_req", first_req, 32'h100);
      chk("t4_first_pc", first_pc, 32'h100);

      // 5: address wrap
      dly_min = 0; dly_max = 0; wrap_seen = 0;
      step(1, 32'hFFFF_FFF8, 1);
      repeat (20) step(0, 0, 1);
      chk("t5_first_req", first_req, 32'hFFFF_FFF8);
      chk("t5_first_pc", first_pc, 32'hFFFF_FFF8);
      chk("t5_wrap", 32'(wrap_seen), 32'd1);

      // Random traffic with random redirects
      rdy_pct = 60; dly_min = 0; dly_max = 3;
      for (int i = 0; i < 400; i++)
         step($urandom_range(29) == 0, $urandom, $urandom_range(3) != 0);

`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, 32'(pops));
      chk("perf_stall", perf_stall, 32'(stalls));
`endif

      // 6: asynchronous reset mid-run
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("mrst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("mrst_inst", bus.inst, 32'd0);
      chk("mrst_inst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("mrst_perf_fetched", perf_fetched, 32'd0);
      chk("mrst_perf_stall", perf_stall, 32'd0);
`endif
      bus.imem_rsp_valid = 0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      rdy_pct = 100; dly_min = 0; dly_max = 1;
      for (int i = 0; i < 40; i++) step(0, 0, $urandom_range(1));
      chk("post_rst_first_pc", first_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched2", perf_fetched, 32'(pops));
      chk("perf_stall2", perf_stall, 32'(stalls));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
